// File: rtl/instr_packer.sv
// Packs decoded RV32 R/I/S/B fields into instruction words and streams them
// into instruction memory through a single-entry write register with backpressure.
module instr_packer #(
  parameter int address_width = 32,
  parameter int ADDR_WIDTH    = 8,
  parameter int DEPTH         = 256
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            stop,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [1:0]                      fmt,
  input  logic [6:0]                      opcode,
  input  logic [4:0]                      rd,
  input  logic [4:0]                      rs1,
  input  logic [4:0]                      rs2,
  input  logic [2:0]                      funct3,
  input  logic [6:0]                      funct7,
  input  logic signed [address_width-1:0] imm,
  output logic                            we,
  input  logic                            wready,
  output logic [ADDR_WIDTH-1:0]           waddr,
  output logic [address_width-1:0]        wdata,
  output logic [ADDR_WIDTH:0]             count,
  output logic                            full,
  output logic                            range_err,
  output logic                            busy
);

  localparam logic [1:0] FMT_R = 2'd0;
  localparam logic [1:0] FMT_I = 2'd1;
  localparam logic [1:0] FMT_S = 2'd2;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_FULL   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  function automatic logic [address_width-1:0] pack_word(
    input logic [1:0]  f,
    input logic [6:0]  opc,
    input logic [4:0]  d,
    input logic [4:0]  r1,
    input logic [4:0]  r2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [12:0] im
  );
    logic [address_width-1:0] w;
    case (f)
      FMT_R:   w = {f7, r2, r1, f3, d, opc};
      FMT_I:   w = {im[11:0], r1, f3, d, opc};
      FMT_S:   w = {im[11:5], r2, r1, f3, im[4:0], opc};
      default: w = {im[12], im[10:5], r2, r1, f3, im[4:1], im[11], opc};
    endcase
    return w;
  endfunction

  // I/S take a 12-bit signed immediate; B takes a 13-bit even offset.
  function automatic logic imm_in_range(
    input logic [1:0]                      f,
    input logic signed [address_width-1:0] im
  );
    logic ok;
    case (f)
      FMT_R:        ok = 1'b1;
      FMT_I, FMT_S: ok = (im >= -2048) && (im <= 2047);
      default:      ok = (im >= -4096) && (im <= 4094) && !im[0];
    endcase
    return ok;
  endfunction

  state_t                   state, state_n;
  logic                     stop_pend, stop_pend_n;
  logic                     we_n;
  logic [ADDR_WIDTH-1:0]    waddr_n;
  logic [address_width-1:0] wdata_n;
  logic [ADDR_WIDTH:0]      count_n;
  logic                     full_n;
  logic                     range_err_n;
  logic [ADDR_WIDTH:0]      issued;
  logic                     accept, load, wdone;
  logic [address_width-1:0] enc_p0;
  logic                     ok_p0;

  assign enc_p0 = pack_word(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm[12:0]);
  assign ok_p0  = imm_in_range(fmt, imm);

  always_comb begin
    state_n     = state;
    stop_pend_n = stop_pend;
    issued      = count + {{ADDR_WIDTH{1'b0}}, we};
    in_ready    = (state == S_ACTIVE) && !stop && !stop_pend && (!we || wready) &&
                  (issued < DEPTH_C);
    accept      = in_valid && in_ready;
    load        = accept && ok_p0;
    wdone       = we && wready;
    // start discards any pending word but a same-cycle accept still loads at address 0
    we_n        = load || (we && !wready && !start);
    wdata_n     = load ? enc_p0 : wdata;
    waddr_n     = start ? '0 : waddr + {{(ADDR_WIDTH-1){1'b0}}, wdone};
    count_n     = start ? '0 : count + {{ADDR_WIDTH{1'b0}}, wdone};
    full_n      = (count_n == DEPTH_C);
    range_err_n = (range_err && !start) || (accept && !ok_p0);
    busy        = (state == S_ACTIVE) || we;

    if (start) begin
      state_n     = S_ACTIVE;
      stop_pend_n = 1'b0;
    end else if (state == S_ACTIVE) begin
      if (count_n == DEPTH_C) begin
        state_n     = S_FULL;
        stop_pend_n = 1'b0;
      end else if ((stop || stop_pend) && !we_n) begin
        state_n     = S_DONE;
        stop_pend_n = 1'b0;
      end else if (stop) begin
        stop_pend_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      stop_pend <= 1'b0;
    end else begin
      state     <= state_n;
      stop_pend <= stop_pend_n;
    end
  end

  // output register stage: pending word, address and commit counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we        <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
      count     <= '0;
      full      <= 1'b0;
      range_err <= 1'b0;
    end else begin
      we        <= we_n;
      waddr     <= waddr_n;
      wdata     <= wdata_n;
      count     <= count_n;
      full      <= full_n;
      range_err <= range_err_n;
    end
  end

endmodule

// File: tb/tb_instr_packer.sv
// Scoreboard bench for instr_packer: directed scenarios plus randomized programs
// checked against an arithmetic encoding model.
module tb_instr_packer;
  localparam int AW = 8;
  localparam int DP = 4;

  logic              clk = 1'b0;
  logic              rst_n, start, stop, in_valid, in_ready;
  logic [1:0]        fmt;
  logic [6:0]        opcode, funct7;
  logic [4:0]        rd, rs1, rs2;
  logic [2:0]        funct3;
  logic signed [31:0] imm;
  logic              we, wready, full, range_err, busy;
  logic [AW-1:0]     waddr;
  logic [31:0]       wdata;
  logic [AW:0]       count;

  logic wr_dir = 1'b1;
  logic wr_rnd = 1'b1;
  bit   rand_wr = 1'b0;
  assign wready = rand_wr ? wr_rnd : wr_dir;

  always #5 clk = ~clk;

  instr_packer #(.address_width(32), .ADDR_WIDTH(AW), .DEPTH(DP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode),
    .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
    .we(we), .wready(wready), .waddr(waddr), .wdata(wdata), .count(count),
    .full(full), .range_err(range_err), .busy(busy)
  );

  typedef struct packed { logic [AW-1:0] a; logic [31:0] d; } wr_t;
  wr_t exp_q[$];
  int  hs_cyc[$];
  int  cyc = 0;
  int  n_chk = 0;
  int  n_fail = 0;
  int  exp_addr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s", nm);
  endtask

  function automatic bit model_ok(input int f, input int im);
    case (f)
      0:       return 1'b1;
      1, 2:    return (im >= -2048) && (im <= 2047);
      default: return (im >= -4096) && (im <= 4094) && (im % 2 == 0);
    endcase
  endfunction

  // Field placement by weighted sums of bit-field values.
  function automatic logic [31:0] model_word(input int f, input int op, input int d,
                                             input int r1, input int r2, input int f3,
                                             input int f7, input int im);
    longint u, w, base;
    u    = longint'($unsigned(im));
    base = longint'(r1) * (64'd1 << 15) + longint'(f3) * (64'd1 << 12) + longint'(op);
    case (f)
      0: w = base + longint'(f7) * (64'd1 << 25) + longint'(r2) * (64'd1 << 20) +
             longint'(d) * (64'd1 << 7);
      1: w = base + (u % 4096) * (64'd1 << 20) + longint'(d) * (64'd1 << 7);
      2: w = base + ((u / 32) % 128) * (64'd1 << 25) + longint'(r2) * (64'd1 << 20) +
             (u % 32) * (64'd1 << 7);
      default: w = base + ((u / 4096) % 2) * (64'd1 << 31) + ((u / 32) % 64) * (64'd1 << 25) +
                   longint'(r2) * (64'd1 << 20) + ((u / 2) % 16) * (64'd1 << 8) +
                   ((u / 2048) % 2) * (64'd1 << 7);
    endcase
    return w[31:0];
  endfunction

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
    #1;
    wr_rnd = ($urandom % 4) != 0;
  end

  // Monitor: every completed write must match the oldest expected word.
  initial forever begin
    wr_t e;
    @(negedge clk);
    if (rst_n === 1'b1 && we === 1'b1 && wready === 1'b1) begin
      if (exp_q.size() == 0) begin
        bad("unexpected_write");
      end else begin
        e = exp_q.pop_front();
        chk("waddr", 64'(waddr), 64'(e.a));
        chk("wdata", 64'(wdata), 64'(e.d));
        hs_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_addr = 0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic issue(input int f, input int op, input int d, input int r1, input int r2,
                       input int f3, input int f7, input int im,
                       input bit expect_ok, input logic [31:0] expw);
    int k;
    wr_t e;
    fmt = 2'(f); opcode = 7'(op); rd = 5'(d); rs1 = 5'(r1); rs2 = 5'(r2);
    funct3 = 3'(f3); funct7 = 7'(f7); imm = im;
    in_valid = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!in_ready && k < 200);
    if (!in_ready) begin
      bad("accept_timeout");
    end else if (expect_ok) begin
      e.a = AW'(exp_addr);
      e.d = expw;
      exp_q.push_back(e);
      exp_addr++;
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((exp_q.size() != 0 || we || busy && stop) && k < 200);
    if (exp_q.size() != 0 || we) bad("drain_timeout");
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  int imm_tab[12] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, 4096, -4098, 1, -1, 0};

  initial begin
    int n, okc, errs, f, im, sel;
    bit ok;
    logic [31:0] w;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0;
    fmt = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_we", 64'(we), 0);
    chk("rst_waddr", 64'(waddr), 0);
    chk("rst_wdata", 64'(wdata), 0);
    chk("rst_count", 64'(count), 0);
    chk("rst_full", 64'(full), 0);
    chk("rst_range_err", 64'(range_err), 0);
    chk("rst_in_ready", 64'(in_ready), 0);
    chk("rst_busy", 64'(busy), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // single I-type addi x1, x0, 5
    do_start();
    issue(1, 'h13, 1, 0, 0, 0, 0, 5, 1'b1, 32'h00500093);
    drain();
    chk("t1_count", 64'(count), 1);

    // back-to-back R, S, B
    do_start();
    hs_cyc.delete();
    issue(0, 'h33, 3, 1, 2, 0, 0, 0, 1'b1, 32'h002081B3);
    issue(2, 'h23, 0, 1, 2, 2, 0, 8, 1'b1, 32'h0020A423);
    issue(3, 'h63, 0, 1, 2, 0, 0, -8, 1'b1, 32'hFE208CE3);
    drain();
    chk("t2_count", 64'(count), 3);
    if (hs_cyc.size() == 3) chk("t2_b2b_span", 64'(hs_cyc[2] - hs_cyc[0]), 2);
    else bad("t2_b2b_writes");

    // range errors
    do_start();
    issue(1, 'h13, 1, 0, 0, 0, 0, 2048, 1'b0, 32'h0);
    chk("t3_we", 64'(we), 0);
    chk("t3_range_err", 64'(range_err), 1);
    chk("t3_waddr", 64'(waddr), 0);
    issue(3, 'h63, 0, 1, 2, 0, 0, 3, 1'b0, 32'h0);
    chk("t3_range_err_b", 64'(range_err), 1);
    chk("t3_count_err", 64'(count), 0);
    issue(1, 'h13, 1, 0, 0, 0, 0, 5, 1'b1, 32'h00500093);
    drain();
    chk("t3_count", 64'(count), 1);
    chk("t3_range_err_sticky", 64'(range_err), 1);

    // backpressure
    do_start();
    wr_dir = 1'b0;
    issue(1, 'h13, 5, 6, 0, 0, 0, -1, 1'b1, 32'hFFF30293);
    repeat (3) begin
      @(negedge clk);
      chk("t4_we_hold", 64'(we), 1);
      chk("t4_wdata_hold", 64'(wdata), 64'h0FFF30293);
      chk("t4_waddr_hold", 64'(waddr), 0);
      chk("t4_in_ready", 64'(in_ready), 0);
      chk("t4_count_hold", 64'(count), 0);
      tick();
    end
    wr_dir = 1'b1;
    tick();
    chk("t4_count", 64'(count), 1);
    chk("t4_in_ready_after", 64'(in_ready), 1);

    // full limit with DEPTH=4
    do_start();
    for (int i = 0; i < 4; i++)
      issue(1, 'h13, i + 1, 0, 0, 0, 0, i * 3, 1'b1, model_word(1, 'h13, i + 1, 0, 0, 0, 0, i * 3));
    fmt = 2'd1; opcode = 7'h13; imm = 32'sd7; in_valid = 1'b1;
    repeat (4) tick();
    chk("t5_full", 64'(full), 1);
    chk("t5_in_ready", 64'(in_ready), 0);
    chk("t5_count", 64'(count), 4);
    chk("t5_busy", 64'(busy), 0);
    in_valid = 1'b0;
    do_start();
    chk("t5_restart_count", 64'(count), 0);
    chk("t5_restart_full", 64'(full), 0);
    chk("t5_restart_in_ready", 64'(in_ready), 1);

    // reset while a write is stalled
    wr_dir = 1'b0;
    issue(1, 'h13, 1, 0, 0, 0, 0, 9, 1'b1, model_word(1, 'h13, 1, 0, 0, 0, 0, 9));
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("t6_pre_we", 64'(we), 1);
    tick();
    chk("t6_we", 64'(we), 0);
    chk("t6_count", 64'(count), 0);
    chk("t6_busy", 64'(busy), 0);
    chk("t6_in_ready", 64'(in_ready), 0);
    rst_n = 1'b1;
    wr_dir = 1'b1;
    tick();
    do_start();
    chk("t6_busy_active", 64'(busy), 1);
    do_stop();
    chk("t6_done_busy", 64'(busy), 0);
    chk("t6_done_in_ready", 64'(in_ready), 0);

    // stop while a word is pending waits for the write
    do_start();
    wr_dir = 1'b0;
    issue(0, 'h33, 7, 8, 9, 0, 'h20, 0, 1'b1, model_word(0, 'h33, 7, 8, 9, 0, 'h20, 0));
    do_stop();
    chk("t7_busy_pending", 64'(busy), 1);
    chk("t7_in_ready", 64'(in_ready), 0);
    wr_dir = 1'b1;
    tick();
    chk("t7_busy_done", 64'(busy), 0);
    chk("t7_count", 64'(count), 1);

    // randomized programs
    rand_wr = 1'b1;
    for (int p = 0; p < 25; p++) begin
      do_start();
      n = $urandom_range(1, 7);
      okc = 0;
      errs = 0;
      for (int k = 0; k < n && okc < DP; k++) begin
        f = $urandom % 4;
        sel = $urandom % 4;
        case (sel)
          0: im = $urandom_range(0, 40) - 20;
          1: im = imm_tab[$urandom % 12];
          2: im = $urandom;
          default: im = $urandom_range(0, 8400) - 4200;
        endcase
        ok = model_ok(f, im);
        w = 32'h0;
        n = n;
        begin
          int op, d, r1, r2, f3, f7;
          op = $urandom % 128; d = $urandom % 32; r1 = $urandom % 32;
          r2 = $urandom % 32; f3 = $urandom % 8; f7 = $urandom % 128;
          w = model_word(f, op, d, r1, r2, f3, f7, im);
          if (ok) okc++; else errs++;
          issue(f, op, d, r1, r2, f3, f7, im, ok, w);
        end
        repeat ($urandom % 2) tick();
      end
      do_stop();
      begin
        int k;
        k = 0;
        do begin
          @(negedge clk);
          k++;
        end while ((busy || exp_q.size() != 0) && k < 200);
        if (busy || exp_q.size() != 0) bad("rand_finish_timeout");
        tick();
      end
      chk("rand_count", 64'(count), 64'(okc));
      chk("rand_range_err", 64'(range_err), 64'(errs > 0));
      chk("rand_full", 64'(full), 64'(okc == DP));
    end
    rand_wr = 1'b0;

    chk("queue_empty", 64'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_packer.md
Name: instr_packer

Overview:
- Instruction encoder/writer: the inverse of the immediate sign-extension path. It takes decoded fields (register indices, funct codes, opcode, 32-bit signed immediate, format select) and scatters the immediate back into RV32 R/I/S/B bit positions.
- Writes the packed words sequentially into instruction memory, giving a hardware test-program loader for the single-cycle CPU.
- Uses a valid/ready request handshake, a single-entry output register with write-side backpressure, an address counter, a full limit and a sticky range-error flag.

Parameters:
- address_width, 32, instruction/data word width; fixed at 32.
- ADDR_WIDTH, 8, instruction-memory word-address width.
- DEPTH, 256, maximum number of words written per program; must be <= 2^ADDR_WIDTH.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  synchronous reset, active-low.
- start  in  1  one-cycle pulse: clear counters and error flags, enter ACTIVE.
- stop  in  1  one-cycle pulse: finish the program, enter DONE.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- fmt  in  2  format select: 0=R, 1=I, 2=S, 3=B.
- opcode  in  7  instr[6:0].
- rd  in  5  destination register; ignored for S and B.
- rs1  in  5  source register 1.
- rs2  in  5  source register 2; ignored for I.
- funct3  in  3  instr[14:12].
- funct7  in  7  instr[31:25]; R only.
- imm  in  address_width  signed immediate; ignored for R.
- we  out  1  memory write request.
- wready  in  1  memory accepts the write when we && wready.
- waddr  out  ADDR_WIDTH  word address of the write.
- wdata  out  address_width  packed instruction.
- count  out  ADDR_WIDTH+1  words committed (write handshakes completed).
- full  out  1  count == DEPTH.
- range_err  out  1  sticky: a request was rejected.
- busy  out  1  state is ACTIVE or an output word is pending.

Behaviour:
- Reset: rst_n sampled low at a clock edge forces:
  - state=IDLE; we=0, waddr=0, wdata=0, count=0.
  - full=0, range_err=0, in_ready=0, busy=0.
  - Any pending word is discarded; reset mid-write is legal.
- States:
  - IDLE: start -> ACTIVE.
  - ACTIVE: stop -> DONE once no word is pending, i.e. after the pending write completes. Reaching count==DEPTH -> FULL.
  - FULL: start -> ACTIVE.
  - DONE: start -> ACTIVE.
- start clears count, waddr, range_err and full in every state. If start and stop arrive in the same cycle, start wins.
- in_ready = (state==ACTIVE) && !stop && (!we || wready) && (issued < DEPTH), where issued is count plus the pending word.
- Encoding (combinational on the inputs; registered into wdata on accept):
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
- Range check:
  - I and S: imm must lie in [-2048, 2047].
  - B: imm must lie in [-4096, 4094] and imm[0] must be 0.
  - On failure the request is still consumed (handshake completes), but no word is loaded, range_err is set the next cycle, and waddr/count are unchanged.
- Latency: a valid accept at edge N gives we=1 with wdata/waddr stable from N+1. These values hold unchanged while wready=0.
- Write completion: on we && wready at edge M:
  - count and waddr increment at M.
  - If a new request is accepted at the same edge M, we stays 1 with the new word and waddr+1 (back-to-back, one word per cycle at full throughput).
  - Otherwise we drops to 0.
- waddr wraps modulo 2^ADDR_WIDTH; with DEPTH <= 2^ADDR_WIDTH no wrap occurs within one program.
- full asserts the cycle after the DEPTH-th write completes. in_ready is 0 while full.
- busy = (state==ACTIVE) || we.

Test Plan:
- Reset, start, then I request (opcode 0x13, rd=1, rs1=0, funct3=0, imm=5) with wready=1 -> next cycle we=1, waddr=0, wdata=0x00500093; then count=1.
- Back-to-back R add (funct7=0, rs2=2, rs1=1, rd=3, opcode 0x33), S sw (rs2=2, rs1=1, funct3=2, imm=8, opcode 0x23), B beq (rs1=1, rs2=2, imm=-8, opcode 0x63) -> writes 0x002081B3 @0, 0x0020A423 @1, 0xFE208CE3 @2 on consecutive cycles; count=3.
- Range errors:
  - I imm=2048 -> no we, range_err=1, waddr stays 0.
  - B imm=3 -> range_err stays 1.
  - A following valid I request writes at waddr=0.
- Backpressure: hold wready=0 for 3 cycles after an accept -> we=1 with wdata/waddr unchanged, in_ready=0; wready=1 -> count increments, in_ready=1.
- DEPTH=4: five consecutive requests -> four writes (waddr 0..3), then full=1, in_ready=0, state FULL; start -> count=0, full=0, in_ready=1.
- Reset mid-operation: rst_n low while we=1 and wready=0 -> next edge we=0, count=0, state IDLE; stop with nothing pending -> DONE in 1 cycle, busy=0.
